// File: rtl/sparse_bit_pack.sv
// Sparse index to bitmap packer: collects bit indices into a word, counts distinct set bits.
// Optional duplicate-index detection is enabled by defining SB_DUP_CHECK_EN.

package sparse_bit_pack_pkg;
  typedef logic [7:0] feature_t;
  typedef logic [2:0] feature_idx_t;
  typedef logic [3:0] feature_count_t;
endpackage

module sparse_bit_pack #(
  parameter type sb_data_t  = sparse_bit_pack_pkg::feature_t,
  parameter type sb_idx_t   = sparse_bit_pack_pkg::feature_idx_t,
  parameter type sb_count_t = sparse_bit_pack_pkg::feature_count_t
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      idx_vld,
  input  sb_idx_t   idx_i,
  input  logic      idx_last,
  output logic      idx_rdy,
  output logic      data_vld,
  output sb_data_t  data_o,
  input  logic      ready,
  output sb_count_t count_o,
  output logic      dup_err
);

  localparam int W  = $bits(sb_data_t);
  localparam int IW = $bits(sb_idx_t);

  localparam logic [0:0] SB_ACCUM = 1'b0;
  localparam logic [0:0] SB_SEND  = 1'b1;

  logic [0:0] r_state;
  sb_data_t   r_data;
  sb_count_t  r_count;
  logic       w_accept;
  logic       w_inRange;
  logic       w_bitSet;

  // Only index types that can encode positions beyond the bitmap need a range check.
  generate
    if ((2 ** IW) > W) begin : g_rangeCheck
      assign w_inRange = (32'(idx_i) < 32'(W));
    end else begin : g_noRangeCheck
      assign w_inRange = 1'b1;
    end
  endgenerate

  assign w_accept = idx_vld && (r_state == SB_ACCUM);
  assign w_bitSet = w_inRange && r_data[idx_i];

  assign idx_rdy  = (r_state == SB_ACCUM) && rst_n;
  assign data_vld = (r_state == SB_SEND) && rst_n;
  assign data_o   = r_data;
  assign count_o  = r_count;

`ifdef SB_DUP_CHECK_EN
  logic r_dup;
  assign dup_err = r_dup;
`else
  assign dup_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= SB_ACCUM;
      r_data  <= '0;
      r_count <= '0;
`ifdef SB_DUP_CHECK_EN
      r_dup   <= 1'b0;
`endif
    end else begin
      case (r_state)
        SB_ACCUM: begin
          if (w_accept) begin
            if (w_inRange && !w_bitSet) begin
              r_data[idx_i] <= 1'b1;
              r_count       <= r_count + sb_count_t'(1);
            end
`ifdef SB_DUP_CHECK_EN
            if (w_bitSet) begin
              r_dup <= 1'b1;
            end
`endif
            if (idx_last) begin
              r_state <= SB_SEND;
            end
          end
        end
        SB_SEND: begin
          // Word is held until the consumer takes it, then accumulation restarts from zero.
          if (ready) begin
            r_state <= SB_ACCUM;
            r_data  <= '0;
            r_count <= '0;
`ifdef SB_DUP_CHECK_EN
            r_dup   <= 1'b0;
`endif
          end
        end
        default: begin
          r_state <= SB_ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_bit_pack.sv
// Directed self-checking bench for sparse_bit_pack (W=8); expected dup_err follows SB_DUP_CHECK_EN.

module tb_sparse_bit_pack;

  logic       clk;
  logic       rst_n;
  logic       idx_vld;
  logic [2:0] idx_i;
  logic       idx_last;
  logic       idx_rdy;
  logic       data_vld;
  logic [7:0] data_o;
  logic       ready;
  logic [3:0] count_o;
  logic       dup_err;

  int nCompared;
  int nMismatched;

`ifdef SB_DUP_CHECK_EN
  localparam logic EXP_DUP = 1'b1;
`else
  localparam logic EXP_DUP = 1'b0;
`endif

  sparse_bit_pack dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .idx_vld  (idx_vld),
    .idx_i    (idx_i),
    .idx_last (idx_last),
    .idx_rdy  (idx_rdy),
    .data_vld (data_vld),
    .data_o   (data_o),
    .ready    (ready),
    .count_o  (count_o),
    .dup_err  (dup_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one index for a single cycle; the block must be ready for it.
  task automatic applyStimulus(input logic [2:0] idx, input logic last);
    checkOutput("idx_rdy_before_send", {31'd0, idx_rdy}, 32'd1);
    idx_vld  = 1'b1;
    idx_i    = idx;
    idx_last = last;
    tick();
    idx_vld  = 1'b0;
    idx_last = 1'b0;
  endtask

  task automatic checkWord(input string tag, input logic [7:0] expData,
                           input logic [3:0] expCount, input logic expDup);
    checkOutput({tag, "_vld"},   {31'd0, data_vld}, 32'd1);
    checkOutput({tag, "_data"},  {24'd0, data_o},   {24'd0, expData});
    checkOutput({tag, "_count"}, {28'd0, count_o},  {28'd0, expCount});
    checkOutput({tag, "_dup"},   {31'd0, dup_err},  {31'd0, expDup});
    checkOutput({tag, "_rdy"},   {31'd0, idx_rdy},  32'd0);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_vld"},   {31'd0, data_vld}, 32'd0);
    checkOutput({tag, "_rdy"},   {31'd0, idx_rdy},  32'd1);
    checkOutput({tag, "_data"},  {24'd0, data_o},   32'd0);
    checkOutput({tag, "_count"}, {28'd0, count_o},  32'd0);
    checkOutput({tag, "_dup"},   {31'd0, dup_err},  32'd0);
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst_n    = 1'b0;
    idx_vld  = 1'b0;
    idx_i    = 3'd0;
    idx_last = 1'b0;
    ready    = 1'b0;

    // Reset: handshake outputs low while reset is held.
    tick();
    tick();
    checkOutput("reset_rdy", {31'd0, idx_rdy},  32'd0);
    checkOutput("reset_vld", {31'd0, data_vld}, 32'd0);
    rst_n = 1'b1;
    #1;
    checkIdle("after_reset");

    // Basic word 1,3,7.
    ready = 1'b1;
    applyStimulus(3'd1, 1'b0);
    applyStimulus(3'd3, 1'b0);
    checkOutput("partial_vld", {31'd0, data_vld}, 32'd0);
    checkOutput("partial_data", {24'd0, data_o}, 32'h0A);
    applyStimulus(3'd7, 1'b1);
    checkWord("w8A", 8'h8A, 4'd3, 1'b0);
    tick();
    checkIdle("w8A_done");

    // Duplicate index 2,2,5.
    applyStimulus(3'd2, 1'b0);
    applyStimulus(3'd2, 1'b0);
    applyStimulus(3'd5, 1'b1);
    checkWord("w24", 8'h24, 4'd2, EXP_DUP);
    tick();
    checkIdle("w24_done");

    // Backpressure on word 8'h01.
    ready = 1'b0;
    applyStimulus(3'd0, 1'b1);
    checkWord("bp_first", 8'h01, 4'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkWord("bp_hold", 8'h01, 4'd1, 1'b0);
    end
    ready = 1'b1;
    tick();
    checkIdle("bp_release");

    // Full word 0..7.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'(i), (i == 7) ? 1'b1 : 1'b0);
    end
    checkWord("wFF", 8'hFF, 4'd8, 1'b0);
    tick();
    checkIdle("wFF_done");

    // Reset mid-word discards 4 and 6.
    applyStimulus(3'd4, 1'b0);
    applyStimulus(3'd6, 1'b0);
    checkOutput("midrst_partial", {24'd0, data_o}, 32'h50);
    checkOutput("midrst_vld_pre", {31'd0, data_vld}, 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_rdy_low", {31'd0, idx_rdy}, 32'd0);
    tick();
    checkOutput("midrst_vld_low", {31'd0, data_vld}, 32'd0);
    rst_n = 1'b1;
    #1;
    checkIdle("midrst_cleared");
    applyStimulus(3'd0, 1'b1);
    checkWord("midrst_w01", 8'h01, 4'd1, 1'b0);
    tick();
    checkIdle("midrst_done");

    // Continuous idx_vld across a word boundary.
    ready    = 1'b0;
    idx_vld  = 1'b1;
    idx_i    = 3'd1;
    idx_last = 1'b0;
    tick();
    idx_i    = 3'd2;
    idx_last = 1'b1;
    tick();
    idx_i    = 3'd4;
    idx_last = 1'b0;
    checkWord("cont_w06", 8'h06, 4'd2, 1'b0);
    tick();
    checkWord("cont_hold", 8'h06, 4'd2, 1'b0);
    ready = 1'b1;
    tick();
    checkIdle("cont_release");
    tick();
    checkOutput("cont_next_data",  {24'd0, data_o},  32'h10);
    checkOutput("cont_next_count", {28'd0, count_o}, 32'd1);
    idx_i    = 3'd6;
    idx_last = 1'b1;
    tick();
    idx_vld  = 1'b0;
    idx_last = 1'b0;
    checkWord("cont_w50", 8'h50, 4'd2, 1'b0);
    tick();
    checkIdle("cont_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
